// File: rtl/pbs_loop_seq_if.sv
// Command/config and index-beat bundle between the PBS front-end, the loop
// sequencer and the BSK/GLWE address generators.
interface pbs_loop_seq_if #(
  parameter int N_MAX      = 2048,
  parameter int GLWE_K_MAX = 2,
  parameter int PBS_L_MAX  = 4,
  parameter int LWE_K_MAX  = 1024,
  parameter int CHUNK      = 32
);
  localparam int LWE_W  = ($clog2(LWE_K_MAX) > 0) ? $clog2(LWE_K_MAX) : 1;
  localparam int POLY_W = ($clog2(GLWE_K_MAX + 1) > 0) ? $clog2(GLWE_K_MAX + 1) : 1;
  localparam int LVL_W  = ($clog2(PBS_L_MAX) > 0) ? $clog2(PBS_L_MAX) : 1;
  localparam int CHK_W  = ($clog2(N_MAX / CHUNK) > 0) ? $clog2(N_MAX / CHUNK) : 1;
  localparam int NLOG_W = ($clog2($clog2(N_MAX) + 1) > 0) ? $clog2($clog2(N_MAX) + 1) : 1;

  logic [POLY_W-1:0] cfg_glwe_k;
  logic [LVL_W:0]    cfg_pbs_l;
  logic [LWE_W:0]    cfg_lwe_k;
  logic [NLOG_W-1:0] cfg_n_log;
  logic              start_vld;
  logic              start_rdy;
  logic              abort;
  logic              out_vld;
  logic              out_rdy;
  logic [LWE_W-1:0]  out_lwe_idx;
  logic [POLY_W-1:0] out_poly_idx;
  logic [LVL_W-1:0]  out_lvl_idx;
  logic [CHK_W-1:0]  out_chunk_idx;
  logic              out_sol;
  logic              out_eol;
  logic              out_last;
  logic              busy;
  logic              cfg_err;

  modport master (
    output cfg_glwe_k, cfg_pbs_l, cfg_lwe_k, cfg_n_log, start_vld, abort, out_rdy,
    input  start_rdy, out_vld, out_lwe_idx, out_poly_idx, out_lvl_idx, out_chunk_idx,
    input  out_sol, out_eol, out_last, busy, cfg_err
  );

  modport slave (
    input  cfg_glwe_k, cfg_pbs_l, cfg_lwe_k, cfg_n_log, start_vld, abort, out_rdy,
    output start_rdy, out_vld, out_lwe_idx, out_poly_idx, out_lvl_idx, out_chunk_idx,
    output out_sol, out_eol, out_last, busy, cfg_err
  );
endinterface

// File: rtl/pbs_loop_seq.sv
// Runtime-configurable PBS loop sequencer: walks lwe (outer), poly*L+lvl
// (middle) and chunk (inner) indices, one registered beat per handshake.
module pbs_loop_seq #(
  parameter int N_MAX      = 2048,
  parameter int GLWE_K_MAX = 2,
  parameter int PBS_L_MAX  = 4,
  parameter int LWE_K_MAX  = 1024,
  parameter int CHUNK      = 32
) (
  input  logic          clk,
  input  logic          s_rst_n,
  pbs_loop_seq_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a start handshake; config latched and checked here
  // RUN   | emitting index beats until the last beat is accepted or abort

  localparam int LWE_W     = ($clog2(LWE_K_MAX) > 0) ? $clog2(LWE_K_MAX) : 1;
  localparam int POLY_W    = ($clog2(GLWE_K_MAX + 1) > 0) ? $clog2(GLWE_K_MAX + 1) : 1;
  localparam int LVL_W     = ($clog2(PBS_L_MAX) > 0) ? $clog2(PBS_L_MAX) : 1;
  localparam int CHK_W     = ($clog2(N_MAX / CHUNK) > 0) ? $clog2(N_MAX / CHUNK) : 1;
  localparam int NLOG_W    = ($clog2($clog2(N_MAX) + 1) > 0) ? $clog2($clog2(N_MAX) + 1) : 1;
  localparam int CHUNK_LOG = $clog2(CHUNK);
  localparam int NMAX_LOG  = $clog2(N_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [LWE_W-1:0]  lwe_q, lwe_d, lwe_max_q, lwe_max_d;
  logic [POLY_W-1:0] poly_q, poly_d, poly_max_q, poly_max_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d, lvl_max_q, lvl_max_d;
  logic [CHK_W-1:0]  chk_q, chk_d, chk_max_q, chk_max_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_legal;
  logic [CHK_W:0]    chk_beats;
  logic              chk_wrap, lvl_wrap, poly_wrap, lwe_wrap;

  always_comb begin
    cfg_legal = (bus.cfg_glwe_k != '0)
             && (bus.cfg_glwe_k <= POLY_W'(GLWE_K_MAX))
             && (bus.cfg_pbs_l != '0)
             && (bus.cfg_pbs_l <= (LVL_W+1)'(PBS_L_MAX))
             && (bus.cfg_lwe_k != '0)
             && (bus.cfg_lwe_k <= (LWE_W+1)'(LWE_K_MAX))
             && (bus.cfg_n_log >= NLOG_W'(CHUNK_LOG))
             && (bus.cfg_n_log <= NLOG_W'(NMAX_LOG));
    // Only meaningful when the config is legal; otherwise never latched.
    chk_beats = (CHK_W+1)'(1) << (bus.cfg_n_log - NLOG_W'(CHUNK_LOG));
  end

  assign chk_wrap  = (chk_q == chk_max_q);
  assign lvl_wrap  = chk_wrap && (lvl_q == lvl_max_q);
  assign poly_wrap = lvl_wrap && (poly_q == poly_max_q);
  assign lwe_wrap  = poly_wrap && (lwe_q == lwe_max_q);

  always_comb begin
    state_d    = state_q;
    lwe_d      = lwe_q;
    poly_d     = poly_q;
    lvl_d      = lvl_q;
    chk_d      = chk_q;
    lwe_max_d  = lwe_max_q;
    poly_max_d = poly_max_q;
    lvl_max_d  = lvl_max_q;
    chk_max_d  = chk_max_q;
    cfg_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_vld) begin
          if (cfg_legal) begin
            state_d    = RUN;
            lwe_d      = '0;
            poly_d     = '0;
            lvl_d      = '0;
            chk_d      = '0;
            lwe_max_d  = LWE_W'(bus.cfg_lwe_k - (LWE_W+1)'(1));
            poly_max_d = bus.cfg_glwe_k;
            lvl_max_d  = LVL_W'(bus.cfg_pbs_l - (LVL_W+1)'(1));
            chk_max_d  = CHK_W'(chk_beats - (CHK_W+1)'(1));
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          lwe_d   = '0;
          poly_d  = '0;
          lvl_d   = '0;
          chk_d   = '0;
        end else if (bus.out_rdy) begin
          chk_d  = chk_wrap  ? '0 : chk_q + CHK_W'(1);
          if (chk_wrap)  lvl_d  = lvl_wrap  ? '0 : lvl_q + LVL_W'(1);
          if (lvl_wrap)  poly_d = poly_wrap ? '0 : poly_q + POLY_W'(1);
          if (poly_wrap) lwe_d  = lwe_wrap  ? '0 : lwe_q + LWE_W'(1);
          if (lwe_wrap)  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      lwe_q      <= '0;
      poly_q     <= '0;
      lvl_q      <= '0;
      chk_q      <= '0;
      lwe_max_q  <= '0;
      poly_max_q <= '0;
      lvl_max_q  <= '0;
      chk_max_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lwe_q      <= lwe_d;
      poly_q     <= poly_d;
      lvl_q      <= lvl_d;
      chk_q      <= chk_d;
      lwe_max_q  <= lwe_max_d;
      poly_max_q <= poly_max_d;
      lvl_max_q  <= lvl_max_d;
      chk_max_q  <= chk_max_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Every output is a function of registers only, so stalls hold them stable.
  assign bus.start_rdy     = (state_q == IDLE);
  assign bus.busy          = (state_q == RUN);
  assign bus.out_vld       = (state_q == RUN);
  assign bus.out_lwe_idx   = lwe_q;
  assign bus.out_poly_idx  = poly_q;
  assign bus.out_lvl_idx   = lvl_q;
  assign bus.out_chunk_idx = chk_q;
  assign bus.out_sol       = (state_q == RUN) && (chk_q == '0) && (lvl_q == '0) && (poly_q == '0);
  assign bus.out_eol       = (state_q == RUN) && poly_wrap;
  assign bus.out_last      = (state_q == RUN) && lwe_wrap;
  assign bus.cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_pbs_loop_seq.sv
// Directed and randomized bench for pbs_loop_seq, checked against a nested-loop
// reference of the expected beat stream.
module tb_pbs_loop_seq;
  logic clk = 1'b0;
  logic s_rst_n;
  always #5 clk = ~clk;

  pbs_loop_seq_if bus();
  pbs_loop_seq dut (.clk(clk), .s_rst_n(s_rst_n), .bus(bus));

  typedef struct {
    int lwe;
    int poly;
    int lvl;
    int cidx;
    bit sol;
    bit eol;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_asrt = 0;
  int    n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit cfg_ok(int g, int l, int k, int n);
    return (g >= 1) && (g <= 2) && (l >= 1) && (l <= 4) && (k >= 1) && (k <= 1024)
        && ((1 << n) >= 32) && ((1 << n) <= 2048);
  endfunction

  function automatic void build(int g, int l, int k, int n);
    int nch;
    beat_t b;
    nch = (1 << n) / 32;
    for (int w = 0; w < k; w++)
      for (int p = 0; p <= g; p++)
        for (int v = 0; v < l; v++)
          for (int c = 0; c < nch; c++) begin
            b.lwe  = w;
            b.poly = p;
            b.lvl  = v;
            b.cidx = c;
            b.sol  = (p == 0) && (v == 0) && (c == 0);
            b.eol  = (p == g) && (v == l - 1) && (c == nch - 1);
            b.last = b.eol && (w == k - 1);
            exp_q.push_back(b);
          end
  endfunction

  task automatic drive_cfg(int g, int l, int k, int n);
    bus.cfg_glwe_k = 2'(g);
    bus.cfg_pbs_l  = 3'(l);
    bus.cfg_lwe_k  = 11'(k);
    bus.cfg_n_log  = 4'(n);
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_vld"}, bus.out_vld, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_start_rdy"}, bus.start_rdy, 1);
    chk({tag, "_sol"}, bus.out_sol, 0);
    chk({tag, "_eol"}, bus.out_eol, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_lwe"}, bus.out_lwe_idx, 0);
    chk({tag, "_poly"}, bus.out_poly_idx, 0);
    chk({tag, "_lvl"}, bus.out_lvl_idx, 0);
    chk({tag, "_chunk"}, bus.out_chunk_idx, 0);
    chk({tag, "_cfg_err"}, bus.cfg_err, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic start_run(int g, int l, int k, int n, bit with_abort);
    drive_cfg(g, l, k, n);
    bus.start_vld = 1'b1;
    bus.abort     = with_abort;
    chk("start_rdy", bus.start_rdy, 1);
    @(negedge clk);
    bus.start_vld = 1'b0;
    bus.abort     = 1'b0;
    if (cfg_ok(g, l, k, n)) begin
      build(g, l, k, n);
    end else begin
      chk("cfg_err_pulse", bus.cfg_err, 1);
      chk("bad_busy", bus.busy, 0);
      chk("bad_vld", bus.out_vld, 0);
      @(negedge clk);
      chk("cfg_err_clear", bus.cfg_err, 0);
      chk("bad_busy2", bus.busy, 0);
      chk("bad_vld2", bus.out_vld, 0);
    end
  endtask

  task automatic run_stream(int rdy_pct, int abort_at, int rst_at);
    int popped = 0;
    int budget = exp_q.size() * 20 + 100;
    beat_t b;
    while (exp_q.size() > 0) begin
      if (budget == 0) begin
        chk("timeout_beats_left", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      budget--;
      b = exp_q[0];
      chk("vld", bus.out_vld, 1);
      chk("busy", bus.busy, 1);
      chk("start_rdy_run", bus.start_rdy, 0);
      chk("lwe", bus.out_lwe_idx, b.lwe);
      chk("poly", bus.out_poly_idx, b.poly);
      chk("lvl", bus.out_lvl_idx, b.lvl);
      chk("chunk", bus.out_chunk_idx, b.cidx);
      chk("sol", bus.out_sol, b.sol);
      chk("eol", bus.out_eol, b.eol);
      chk("last", bus.out_last, b.last);
      drive_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2047), $urandom_range(0, 15));
      if (popped == abort_at) begin
        bus.abort   = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_vld", bus.out_vld, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_last", bus.out_last, 0);
        chk("abort_start_rdy", bus.start_rdy, 1);
        exp_q.delete();
        return;
      end
      if (popped == rst_at) begin
        s_rst_n     = 1'b0;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        s_rst_n = 1'b1;
        check_idle("midrst");
        exp_q.delete();
        return;
      end
      bus.out_rdy = ($urandom_range(0, 99) < rdy_pct);
      if (bus.out_rdy) begin
        void'(exp_q.pop_front());
        popped++;
      end
      @(negedge clk);
    end
    check_idle("end");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g, l, k, n;
    s_rst_n       = 1'b0;
    bus.start_vld = 1'b0;
    bus.abort     = 1'b0;
    bus.out_rdy   = 1'b0;
    drive_cfg(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_idle("rst");
    s_rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // abort while idle does nothing
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("idle_abort");

    start_run(1, 1, 2, 6, 1'b0);
    run_stream(100, -1, -1);
    start_run(1, 1, 2, 6, 1'b0);
    run_stream(50, -1, -1);
    start_run(2, 3, 1, 11, 1'b0);
    run_stream(75, -1, -1);
    start_run(1, 4, 1, 5, 1'b0);
    run_stream(100, -1, -1);

    start_run(1, 0, 2, 6, 1'b0);
    start_run(1, 1, 2, 4, 1'b0);
    start_run(0, 1, 2, 6, 1'b0);
    start_run(1, 5, 2, 6, 1'b0);
    start_run(1, 1, 1025, 6, 1'b0);
    start_run(1, 1, 0, 6, 1'b0);
    start_run(1, 1, 2, 12, 1'b0);

    start_run(1, 1, 2, 6, 1'b0);
    run_stream(100, 4, -1);
    start_run(1, 1, 2, 6, 1'b1);
    run_stream(100, -1, -1);

    start_run(1, 1, 2, 6, 1'b0);
    run_stream(60, -1, 3);
    start_run(1, 1, 2, 6, 1'b0);
    run_stream(100, -1, -1);
    start_run(2, 2, 2, 5, 1'b0);
    run_stream(100, -1, -1);

    for (int i = 0; i < 8; i++) begin
      g = $urandom_range(0, 2);
      l = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      n = $urandom_range(4, 7);
      start_run(g, l, k, n, 1'b0);
      if (cfg_ok(g, l, k, n)) run_stream(80, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
